// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and hazard-stall unit for an in-order pipeline.
// For each ID source operand it finds the youngest producer stage that
// writes the same register. It registers a forward select for EX, and it
// raises stall/bubble for load-use and memory-wait hazards through a
// two-state controller.
module fwd_hazard_unit #(
  parameter  int NUM_SRC        = 2,
  parameter  int NUM_FWD_STAGES = 2,
  parameter  int REG_ADDR_W     = 5,
  parameter  int LOAD_AVAIL_STG = 1,
  localparam int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      flush_i,
  input  logic                                      id_valid_i,
  input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]        id_rs_i,
  input  logic [NUM_SRC-1:0]                        id_rs_used_i,
  input  logic [NUM_FWD_STAGES-1:0]                 stg_valid_i,
  input  logic [NUM_FWD_STAGES-1:0]                 stg_we_i,
  input  logic [NUM_FWD_STAGES-1:0][REG_ADDR_W-1:0] stg_rd_i,
  input  logic [NUM_FWD_STAGES-1:0]                 stg_is_load_i,
  input  logic                                      mem_ready_i,
  output logic [NUM_SRC-1:0][SEL_W-1:0]             fw_sel_o,
  output logic                                      stall_o,
  output logic                                      bubble_o,
  output logic [31:0]                               stall_cnt_o
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e                        state_q, state_d;
  logic [NUM_SRC-1:0][SEL_W-1:0] sel_d;
  logic [NUM_SRC-1:0][SEL_W-1:0] fw_sel_q, fw_sel_d;
  logic [NUM_SRC-1:0]            src_load_use;
  logic [NUM_SRC-1:0]            src_mem_haz;
  logic                          load_use_any;
  logic                          mem_haz_any;
  logic [31:0]                   stall_cnt_q, stall_cnt_d;

  // Per-source youngest-producer search and hazard classification of the winner.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    sel_d        = '0;
    src_load_use = '0;
    src_mem_haz  = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      // Scan oldest to youngest so the youngest match is written last and wins.
      for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
        if (id_valid_i && id_rs_used_i[s] && stg_valid_i[k] && stg_we_i[k] &&
            (id_rs_i[s] != '0) && (stg_rd_i[k] == id_rs_i[s])) begin
          sel_d[s]        = SEL_W'(k + 1);
          src_load_use[s] = stg_is_load_i[k] && (k < LOAD_AVAIL_STG);
          src_mem_haz[s]  = stg_is_load_i[k] && (k == LOAD_AVAIL_STG) && !mem_ready_i;
        end
      end
    end
  end

  assign load_use_any = |src_load_use;
  assign mem_haz_any  = |src_mem_haz;

  // State register; reset always lands in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      state_q <= state_d;
    end
  end

  // Next-state logic: a load-use hazard outranks a memory hazard; flush always returns to RUN.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:      if (!load_use_any && mem_haz_any) state_d = MEM_WAIT;
        MEM_WAIT: if (mem_ready_i)                  state_d = RUN;
        default:                                    state_d = RUN;
      endcase
    end
  end

  // Output logic: stall/bubble are combinational and held low during reset or flush.
  always_comb begin
    stall_o  = 1'b0;
    bubble_o = 1'b0;
    if (rst && !flush_i) begin
      case (state_q)
        RUN: begin
          if (load_use_any) begin
            stall_o  = 1'b1;
            bubble_o = 1'b1;
          end else if (mem_haz_any) begin
            stall_o = 1'b1;
          end
        end
        MEM_WAIT: stall_o = !mem_ready_i;
        default: ;
      endcase
    end
  end

  // A stalled or flushed cycle sends EX a register-file select.
  assign fw_sel_d = (stall_o || flush_i) ? '0 : sel_d;

  // Saturating stall counter.
  assign stall_cnt_d = (stall_o && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;

  // Forward select and stall counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fw_sel_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      fw_sel_q    <= fw_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fw_sel_o    = fw_sel_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit at default parameters:
// a directed vector table, hand sequences for the multi-cycle cases,
// and random cycles checked against a rule-level reference model.
module tb_fwd_hazard_unit;

  localparam int LAS = 1;

  typedef struct {
    logic       flush;
    logic       idv;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] used;
    logic [1:0] sv;
    logic [1:0] we;
    logic [4:0] rd0;
    logic [4:0] rd1;
    logic [1:0] ld;
    logic       mr;
  } in_t;

  typedef struct {
    in_t        in;
    logic       stall;
    logic       bubble;
    logic [1:0] sel0;
    logic [1:0] sel1;
  } vec_t;

  logic                 clk;
  logic                 rst;
  logic                 flush_i;
  logic                 id_valid_i;
  logic [1:0][4:0]      id_rs_i;
  logic [1:0]           id_rs_used_i;
  logic [1:0]           stg_valid_i;
  logic [1:0]           stg_we_i;
  logic [1:0][4:0]      stg_rd_i;
  logic [1:0]           stg_is_load_i;
  logic                 mem_ready_i;
  logic [1:0][1:0]      fw_sel_o;
  logic                 stall_o;
  logic                 bubble_o;
  logic [31:0]          stall_cnt_o;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  fwd_hazard_unit dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .id_valid_i   (id_valid_i),
    .id_rs_i      (id_rs_i),
    .id_rs_used_i (id_rs_used_i),
    .stg_valid_i  (stg_valid_i),
    .stg_we_i     (stg_we_i),
    .stg_rd_i     (stg_rd_i),
    .stg_is_load_i(stg_is_load_i),
    .mem_ready_i  (mem_ready_i),
    .fw_sel_o     (fw_sel_o),
    .stall_o      (stall_o),
    .bubble_o     (bubble_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic in_t mk(input logic flush, input logic idv,
                             input logic [4:0] rs0, input logic [4:0] rs1,
                             input logic [1:0] used, input logic [1:0] sv,
                             input logic [1:0] we, input logic [4:0] rd0,
                             input logic [4:0] rd1, input logic [1:0] ld,
                             input logic mr);
    in_t v;
    v.flush = flush; v.idv = idv; v.rs0 = rs0; v.rs1 = rs1; v.used = used;
    v.sv = sv; v.we = we; v.rd0 = rd0; v.rd1 = rd1; v.ld = ld; v.mr = mr;
    return v;
  endfunction

  task automatic drive(input in_t v);
    flush_i       = v.flush;
    id_valid_i    = v.idv;
    id_rs_i[0]    = v.rs0;
    id_rs_i[1]    = v.rs1;
    id_rs_used_i  = v.used;
    stg_valid_i   = v.sv;
    stg_we_i      = v.we;
    stg_rd_i[0]   = v.rd0;
    stg_rd_i[1]   = v.rd1;
    stg_is_load_i = v.ld;
    mem_ready_i   = v.mr;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: youngest stage writing the source register, or -1.
  function automatic int winner(input in_t v, input int s);
    logic [4:0] rs;
    logic       used;
    rs   = (s == 0) ? v.rs0 : v.rs1;
    used = v.used[s];
    if (!v.idv || !used || rs == 5'd0) return -1;
    for (int k = 0; k < 2; k++) begin
      if (v.sv[k] && v.we[k] && (((k == 0) ? v.rd0 : v.rd1) == rs)) return k;
    end
    return -1;
  endfunction

  // Model state: whether the pipeline is waiting on memory.
  bit m_wait = 1'b0;

  // One model cycle: expected stall/bubble now, expected selects after the edge.
  task automatic model_cycle(input in_t v, output bit st, output bit bu,
                             output int s0, output int s1);
    int  w [2];
    bit  lu, mh;
    lu = 1'b0;
    mh = 1'b0;
    for (int s = 0; s < 2; s++) begin
      w[s] = winner(v, s);
      if (w[s] >= 0 && v.ld[w[s]] && w[s] < LAS) lu = 1'b1;
      if (w[s] == LAS && v.ld[w[s]] && !v.mr) mh = 1'b1;
    end
    st = 1'b0;
    bu = 1'b0;
    if (v.flush) begin
      m_wait = 1'b0;
    end else if (m_wait) begin
      st     = !v.mr;
      m_wait = !v.mr;
    end else if (lu) begin
      st = 1'b1;
      bu = 1'b1;
    end else if (mh) begin
      st     = 1'b1;
      m_wait = 1'b1;
    end
    s0 = (st || v.flush) ? 0 : w[0] + 1;
    s1 = (st || v.flush) ? 0 : w[1] + 1;
  endtask

  vec_t vecs[$];
  in_t  idle, fl_idle, h, hv;

  initial begin
    bit st, bu;
    int s0, s1;

    idle    = mk(1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 1'b0);
    fl_idle = mk(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 1'b0);
    // Source 0 = x3 produced by a load in stage 1 (memory hazard when mem_ready is 0).
    h       = mk(1'b0, 1'b1, 5'd3, 5'd0, 2'b01, 2'b11, 2'b11, 5'd9, 5'd3, 2'b10, 1'b0);

    //             flush idv  rs0   rs1   used   sv     we     rd0   rd1   ld     mr     st bu s0 s1
    vecs.push_back('{mk(0, 1, 5'd5, 5'd9, 2'b11, 2'b11, 2'b11, 5'd5, 5'd5, 2'b00, 1'b1), 0, 0, 1, 0}); // youngest wins
    vecs.push_back('{mk(0, 1, 5'd1, 5'd7, 2'b11, 2'b11, 2'b11, 5'd7, 5'd2, 2'b01, 1'b1), 1, 1, 0, 0}); // load-use on rs2
    vecs.push_back('{mk(0, 1, 5'd0, 5'd0, 2'b11, 2'b11, 2'b11, 5'd0, 5'd0, 2'b11, 1'b0), 0, 0, 0, 0}); // x0 ignored
    vecs.push_back('{mk(0, 1, 5'd3, 5'd0, 2'b01, 2'b11, 2'b11, 5'd9, 5'd3, 2'b10, 1'b1), 0, 0, 2, 0}); // load ready in stage 1
    vecs.push_back('{mk(0, 1, 5'd3, 5'd0, 2'b01, 2'b11, 2'b11, 5'd9, 5'd3, 2'b10, 1'b0), 1, 0, 0, 0}); // memory hazard
    vecs.push_back('{mk(0, 1, 5'd3, 5'd7, 2'b11, 2'b11, 2'b11, 5'd7, 5'd3, 2'b11, 1'b0), 1, 1, 0, 0}); // both: load-use first
    vecs.push_back('{mk(0, 1, 5'd5, 5'd5, 2'b00, 2'b11, 2'b11, 5'd5, 5'd5, 2'b11, 1'b0), 0, 0, 0, 0}); // sources unused
    vecs.push_back('{mk(0, 1, 5'd5, 5'd6, 2'b11, 2'b11, 2'b00, 5'd5, 5'd6, 2'b00, 1'b1), 0, 0, 0, 0}); // no write enable
    vecs.push_back('{mk(0, 1, 5'd5, 5'd6, 2'b11, 2'b00, 2'b11, 5'd5, 5'd6, 2'b11, 1'b0), 0, 0, 0, 0}); // stages invalid
    vecs.push_back('{mk(0, 0, 5'd5, 5'd6, 2'b11, 2'b11, 2'b11, 5'd5, 5'd6, 2'b01, 1'b0), 0, 0, 0, 0}); // ID invalid
    vecs.push_back('{mk(1, 1, 5'd1, 5'd7, 2'b11, 2'b11, 2'b11, 5'd7, 5'd1, 2'b11, 1'b0), 0, 0, 0, 0}); // flush overrides
    vecs.push_back('{mk(0, 1, 5'd4, 5'd6, 2'b11, 2'b11, 2'b11, 5'd6, 5'd4, 2'b00, 1'b0), 0, 0, 2, 1}); // cross forward
    vecs.push_back('{mk(0, 1, 5'd5, 5'd0, 2'b01, 2'b11, 2'b11, 5'd5, 5'd5, 2'b10, 1'b0), 0, 0, 1, 0}); // ALU shadows load

    // Reset: outputs low while reset is held, even with a load-use hazard presented.
    rst = 1'b0;
    drive(vecs[1].in);
    #3;
    check("rst_stall", 32'(stall_o), 0);
    check("rst_bubble", 32'(bubble_o), 0);
    check("rst_sel", 32'(fw_sel_o), 0);
    check("rst_cnt", stall_cnt_o, 0);
    drive(idle);
    #9 rst = 1'b1;
    tick();

    // Directed vectors, each started from RUN and followed by a flush cycle.
    foreach (vecs[i]) begin
      drive(vecs[i].in);
      #1;
      check($sformatf("vec%0d_stall", i), 32'(stall_o), 32'(vecs[i].stall));
      check($sformatf("vec%0d_bubble", i), 32'(bubble_o), 32'(vecs[i].bubble));
      tick();
      if (vecs[i].stall) exp_cnt++;
      check($sformatf("vec%0d_sel0", i), 32'(fw_sel_o[0]), 32'(vecs[i].sel0));
      check($sformatf("vec%0d_sel1", i), 32'(fw_sel_o[1]), 32'(vecs[i].sel1));
      check($sformatf("vec%0d_cnt", i), stall_cnt_o, exp_cnt);
      drive(fl_idle);
      tick();
    end

    // Memory wait: three stalled cycles, then release with stage-1 forward.
    drive(h);
    #1 check("mw_c1_stall", 32'(stall_o), 1);
    check("mw_c1_bubble", 32'(bubble_o), 0);
    tick(); exp_cnt++;
    check("mw_c1_sel", 32'(fw_sel_o), 0);
    #1 check("mw_c2_stall", 32'(stall_o), 1);
    tick(); exp_cnt++;
    hv = h; hv.sv = 2'b00;
    drive(hv);
    #1 check("mw_c3_wait_holds", 32'(stall_o), 1);
    check("mw_c3_bubble", 32'(bubble_o), 0);
    tick(); exp_cnt++;
    check("mw_cnt3", stall_cnt_o, exp_cnt);
    hv = h; hv.mr = 1'b1;
    drive(hv);
    #1 check("mw_release_stall", 32'(stall_o), 0);
    tick();
    check("mw_release_sel0", 32'(fw_sel_o[0]), 2);
    check("mw_release_sel1", 32'(fw_sel_o[1]), 0);
    check("mw_cnt_final", stall_cnt_o, exp_cnt);
    drive(idle);
    #1 check("mw_back_to_run", 32'(stall_o), 0);
    tick();

    // Flush during MEM_WAIT.
    drive(h);
    #1 check("fl_enter_stall", 32'(stall_o), 1);
    tick(); exp_cnt++;
    hv = h; hv.flush = 1'b1;
    drive(hv);
    #1 check("fl_stall", 32'(stall_o), 0);
    check("fl_bubble", 32'(bubble_o), 0);
    tick();
    check("fl_sel", 32'(fw_sel_o), 0);
    check("fl_cnt", stall_cnt_o, exp_cnt);
    drive(idle);
    #1 check("fl_run", 32'(stall_o), 0);
    tick();

    // Random cycles against the reference model (DUT is in RUN here).
    m_wait = 1'b0;
    for (int n = 0; n < 400; n++) begin
      in_t v;
      v.flush = ($urandom_range(0, 15) == 0);
      v.idv   = ($urandom_range(0, 7) != 0);
      v.rs0   = 5'($urandom_range(0, 3));
      v.rs1   = 5'($urandom_range(0, 3));
      v.used  = 2'($urandom_range(0, 3));
      v.sv    = 2'($urandom_range(0, 3));
      v.we    = 2'($urandom_range(0, 3));
      v.rd0   = 5'($urandom_range(0, 3));
      v.rd1   = 5'($urandom_range(0, 3));
      v.ld    = 2'($urandom_range(0, 3));
      v.mr    = $urandom_range(0, 1);
      drive(v);
      #1;
      model_cycle(v, st, bu, s0, s1);
      check("rnd_stall", 32'(stall_o), 32'(st));
      check("rnd_bubble", 32'(bubble_o), 32'(bu));
      tick();
      if (st) exp_cnt++;
      check("rnd_sel0", 32'(fw_sel_o[0]), 32'(s0));
      check("rnd_sel1", 32'(fw_sel_o[1]), 32'(s1));
      check("rnd_cnt", stall_cnt_o, exp_cnt);
    end

    // Reset asserted mid-stall in MEM_WAIT.
    drive(fl_idle);
    tick();
    drive(h);
    tick(); exp_cnt++;
    #1 check("rs_pre_stall", 32'(stall_o), 1);
    check("rs_pre_cnt_nonzero", 32'(stall_cnt_o != 0), 1);
    rst = 1'b0;
    #1;
    check("rs_stall", 32'(stall_o), 0);
    check("rs_bubble", 32'(bubble_o), 0);
    check("rs_sel", 32'(fw_sel_o), 0);
    check("rs_cnt", stall_cnt_o, 0);
    tick();
    rst = 1'b1;
    exp_cnt = 0;
    drive(idle);
    #1 check("rs_no_residual", 32'(stall_o), 0);
    tick();
    check("rs_cnt_after", stall_cnt_o, 0);
    check("rs_sel_after", 32'(fw_sel_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter NUM_SRC, default 2: number of ID source operands checked; legal range 1..3.
REQ-002 Parameter NUM_FWD_STAGES, default 2: number of producer stages; index 0 is the youngest (EX); legal range 1..7.
REQ-003 Parameter REG_ADDR_W, default 5: register address width.
REQ-004 Parameter LOAD_AVAIL_STG, default 1: first stage index whose load data can be forwarded; legal range 0..NUM_FWD_STAGES-1.
REQ-005 Derived SEL_W = $clog2(NUM_FWD_STAGES+1): select width; 0 = register file, k = stage k-1.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 flush_i  in  1  pipeline flush; forces RUN state and zero selects.
REQ-009 id_valid_i  in  1  ID holds a valid instruction.
REQ-010 id_rs_i  in  NUM_SRC x REG_ADDR_W  ID source register addresses.
REQ-011 id_rs_used_i  in  NUM_SRC  source actually read by the instruction.
REQ-012 stg_valid_i  in  NUM_FWD_STAGES  producer stage holds a valid instruction.
REQ-013 stg_we_i  in  NUM_FWD_STAGES  producer writes rd.
REQ-014 stg_rd_i  in  NUM_FWD_STAGES x REG_ADDR_W  producer destination register.
REQ-015 stg_is_load_i  in  NUM_FWD_STAGES  producer is a load.
REQ-016 mem_ready_i  in  1  load data valid in stage LOAD_AVAIL_STG.
REQ-017 fw_sel_o  out  NUM_SRC x SEL_W  registered per-operand forward select, used by EX.
REQ-018 stall_o  out  1  combinational; hold IF/ID.
REQ-019 bubble_o  out  1  combinational; insert NOP into EX.
REQ-020 stall_cnt_o  out  32  registered, saturating count of stall cycles.

Function
REQ-021 A producer k matches source s when id_valid_i, id_rs_used_i[s], stg_valid_i[k], stg_we_i[k] are all 1, id_rs_i[s] != 0, and stg_rd_i[k] == id_rs_i[s].
REQ-022 For each source, the lowest matching k (youngest) SHALL win; with no match, the select is 0.
REQ-023 The FSM SHALL have two states: RUN and MEM_WAIT.
REQ-024 Load-use hazard: a winning producer k with stg_is_load_i[k]=1 and k < LOAD_AVAIL_STG.
REQ-025 Memory hazard: a winning producer k == LOAD_AVAIL_STG with stg_is_load_i[k]=1 and mem_ready_i=0.
REQ-026 In RUN with a load-use hazard on any source, stall_o=1 and bubble_o=1 in the same cycle; the state stays RUN.
REQ-027 In RUN with a memory hazard and no load-use hazard, stall_o=1 and bubble_o=0; the next state is MEM_WAIT.
REQ-028 In MEM_WAIT, stall_o=1 and bubble_o=0 until mem_ready_i=1; in that cycle stall_o=0 and the next state is RUN.
REQ-029 When both hazards exist, the load-use hazard takes precedence.
REQ-030 At each rising edge, fw_sel_o SHALL load the computed selects when stall_o=0, and SHALL load all zeros when stall_o=1 or flush_i=1 (latency 1 cycle).
REQ-031 flush_i=1 SHALL force stall_o=0 and bubble_o=0 combinationally, and set next state RUN, overriding all hazards.
REQ-032 stall_cnt_o SHALL increment by 1 on each edge where stall_o=1, and saturate at 0xFFFF_FFFF.
REQ-033 Register x0 SHALL never be forwarded or cause a stall.

Reset
REQ-034 With rst=0, asynchronously: state=RUN, fw_sel_o=0, stall_cnt_o=0; stall_o=0 and bubble_o=0 while rst is low.
REQ-035 Reset asserted in MEM_WAIT SHALL return the block to RUN immediately, with no residual stall after deassertion.

Verification (defaults NUM_SRC=2, NUM_FWD_STAGES=2, LOAD_AVAIL_STG=1)
REQ-036 Test priority: rs1=5 with stage0 ALU rd=5 and stage1 rd=5 -> next cycle fw_sel_o[0]=1, fw_sel_o[1]=0.
REQ-037 Test load-use: rs2=7 with stage0 load rd=7 -> stall_o=1, bubble_o=1 that cycle; fw_sel_o=0 next; stall_cnt_o=1.
REQ-038 Test memory wait: rs1=3 with stage1 load rd=3, mem_ready_i=0 for 3 cycles then 1 -> stall_o high for 3 cycles, MEM_WAIT then RUN, fw_sel_o[0]=2 after release.
REQ-039 Test x0: rs1=0 with stage0 rd=0, we=1 -> fw_sel_o=0, no stall.
REQ-040 Test flush: flush_i=1 during MEM_WAIT -> stall_o=0 same cycle, state RUN, fw_sel_o=0 next.
REQ-041 Test reset: rst low mid-stall -> all outputs 0 immediately; stall_cnt_o=0 after release.
